// File: rtl/apb_irq_capture_pkg.sv
// apb_irq_pkg: shared types and register map for the APB interrupt capture front end.
package apb_irq_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_BOTH  = 2'b11
  } irq_mode_t;

  localparam logic [3:0] ADDR_MODE = 4'h0;
  localparam logic [3:0] ADDR_PEND = 4'h4;
  localparam logic [3:0] ADDR_RAW  = 4'h8;

endpackage

// File: rtl/apb_irq_capture_if.sv
// apb_irq_capture_if: APB slave bus bundle for the interrupt capture block.
interface apb_irq_capture_if;
  logic [3:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_irq_capture_chan.sv
// irq_capture_chan: one interrupt source -- synchroniser, optional debounce
// filter (IRQ_CAPTURE_DEBOUNCE_EN), edge detect and sticky pending flop.
module irq_capture_chan
  import apb_irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic      pclk,
  input  logic      reset_n,
  input  logic      enable,
  input  logic      irq_pin,
  input  irq_mode_t mode,
  input  logic      mode_clr,
  input  logic      w1c,
  output logic      raw,
  output logic      irq_req
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic sync_out, s;
  logic prev_q, prev_d;
  logic pend_q, pend_d;
  logic rise, fall, edge_hit;

  // Synchroniser shift chain, frozen while enable is low
  always_comb begin
    sync_d = sync_q;
    if (enable) sync_d = {sync_q[SYNC_STAGES-2:0], irq_pin};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef IRQ_CAPTURE_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Filtered value follows the input only after DEB_CYCLES consecutive differing samples
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (enable) begin
      if (sync_out == filt_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        filt_d = sync_out;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign s = filt_q;
`else
  localparam int unsigned unused_deb_cycles = DEB_CYCLES;
  assign s = sync_out;
`endif

  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  // Edge selection, history tracking and pending set/clear priority
  always_comb begin
    edge_hit = 1'b0;
    unique case (mode)
      MODE_RISE:  edge_hit = rise;
      MODE_FALL:  edge_hit = fall;
      MODE_BOTH:  edge_hit = rise | fall;
      default:    edge_hit = 1'b0;
    endcase

    prev_d = prev_q;
    pend_d = pend_q;
    if (enable) begin
      prev_d = s;
      // Mode change discards both the old pending state and any edge this cycle;
      // otherwise a fresh edge beats a concurrent write-1-to-clear.
      if (mode_clr)                      pend_d = 1'b0;
      else if (edge_hit)                 pend_d = 1'b1;
      else if (w1c && mode != MODE_LEVEL) pend_d = 1'b0;
    end
  end

  // Channel state registers
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

  assign raw     = s;
  assign irq_req = (mode == MODE_LEVEL) ? s : pend_q;

endmodule

// File: rtl/apb_irq_capture.sv
// apb_irq_capture: APB-programmable interrupt capture front end. Holds the MODE
// register and APB decode; per-source logic lives in irq_capture_chan.
// Optional debounce filter enabled by defining IRQ_CAPTURE_DEBOUNCE_EN.
module apb_irq_capture
  import apb_irq_pkg::*;
#(
  parameter int unsigned NIRQ        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic                    pclk,
  input  logic                    reset_n,
  input  logic                    enable,
  apb_irq_capture_if.slave        apb,
  input  logic [NIRQ-1:0]         irq_in,
  output logic [NIRQ-1:0]         irq_request
);

  logic [2*NIRQ-1:0] mode_q, mode_d;
  logic [31:0]       prdata_q, prdata_d;
  logic [NIRQ-1:0]   mode_clr, w1c, raw;
  logic [3:0]        addr_w;
  logic              wr_en, rd_en;
  logic              unused_bits;

  assign addr_w = {apb.paddr[3:2], 2'b00};
  assign wr_en  = apb.psel & apb.penable & apb.pwrite & enable;
  assign rd_en  = apb.psel & ~apb.pwrite & enable;
  assign unused_bits = ^{apb.paddr[1:0], apb.pwdata};

  // MODE register write, per-source mode-change strobes and W1C strobes
  always_comb begin
    mode_d   = mode_q;
    mode_clr = '0;
    w1c      = '0;
    if (wr_en && addr_w == ADDR_MODE) begin
      mode_d = apb.pwdata[2*NIRQ-1:0];
      for (int unsigned i = 0; i < NIRQ; i++)
        mode_clr[i] = (apb.pwdata[2*i +: 2] != mode_q[2*i +: 2]);
    end
    if (wr_en && addr_w == ADDR_PEND) w1c = apb.pwdata[NIRQ-1:0];
  end

  // Registered read data; zero whenever no read is in progress
  always_comb begin
    prdata_d = prdata_q;
    if (enable) begin
      prdata_d = '0;
      if (rd_en) begin
        unique case (addr_w)
          ADDR_MODE: prdata_d[2*NIRQ-1:0] = mode_q;
          ADDR_PEND: prdata_d[NIRQ-1:0]   = irq_request;
          ADDR_RAW:  prdata_d[NIRQ-1:0]   = raw;
          default:   prdata_d = '0;
        endcase
      end
    end
  end

  // Top-level registers
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= '0;
      prdata_q <= '0;
    end else begin
      mode_q   <= mode_d;
      prdata_q <= prdata_d;
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = 1'b0;

  for (genvar g = 0; g < NIRQ; g++) begin : g_chan
    irq_capture_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_chan (
      .pclk     (pclk),
      .reset_n  (reset_n),
      .enable   (enable),
      .irq_pin  (irq_in[g]),
      .mode     (irq_mode_t'(mode_q[2*g +: 2])),
      .mode_clr (mode_clr[g]),
      .w1c      (w1c[g]),
      .raw      (raw[g]),
      .irq_req  (irq_request[g])
    );
  end

endmodule

// File: tb/tb_apb_irq_capture.sv
// tb_apb_irq_capture: directed self-checking bench for apb_irq_capture.
module tb_apb_irq_capture;

  localparam int unsigned NIRQ        = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DEB_CYCLES  = 4;
`ifdef IRQ_CAPTURE_DEBOUNCE_EN
  localparam int unsigned LAT = SYNC_STAGES + DEB_CYCLES;
  localparam int unsigned PW  = DEB_CYCLES + 2;
`else
  localparam int unsigned LAT = SYNC_STAGES;
  localparam int unsigned PW  = 1;
`endif

  logic            pclk = 1'b0;
  logic            reset_n;
  logic            enable;
  logic [NIRQ-1:0] irq_in;
  logic [NIRQ-1:0] irq_request;
  int              tests = 0;
  int              fails = 0;
  logic [31:0]     rd;

  apb_irq_capture_if ifc ();

  apb_irq_capture #(
    .NIRQ        (NIRQ),
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) dut (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .enable      (enable),
    .apb         (ifc),
    .irq_in      (irq_in),
    .irq_request (irq_request)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
    ifc.paddr = addr; ifc.pwdata = data; ifc.pwrite = 1'b1;
    ifc.psel = 1'b1; ifc.penable = 1'b0;
    tick();
    ifc.penable = 1'b1;
    tick();
    ifc.psel = 1'b0; ifc.penable = 1'b0; ifc.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
    ifc.paddr = addr; ifc.pwrite = 1'b0;
    ifc.psel = 1'b1; ifc.penable = 1'b0;
    tick();
    ifc.penable = 1'b1;
    tick();
    data = ifc.prdata;
    ifc.psel = 1'b0; ifc.penable = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; irq_in = '0;
    ifc.paddr = '0; ifc.psel = 1'b0; ifc.penable = 1'b0;
    ifc.pwrite = 1'b0; ifc.pwdata = '0;
    ticks(3);
    reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_irq", 32'(irq_request), 32'h0);
    check("pready", 32'(ifc.pready), 32'h1);
    check("pslverr", 32'(ifc.pslverr), 32'h0);
    check("rst_prdata", ifc.prdata, 32'h0);
    apb_read(4'h0, rd); check("rst_mode", rd, 32'h0);
    apb_read(4'h4, rd); check("rst_pend", rd, 32'h0);
    apb_read(4'h8, rd); check("rst_raw", rd, 32'h0);
    apb_read(4'hC, rd); check("rd_unmapped", rd, 32'h0);

    // Level mode on source 2
    irq_in = 4'b0100;
    ticks(LAT - 1);
    check("lvl_before", 32'(irq_request), 32'h0);
    tick();
    check("lvl_rise", 32'(irq_request), 32'h4);
    apb_read(4'h4, rd); check("lvl_pend_rd", rd, 32'h4);
    apb_read(4'h8, rd); check("lvl_raw_rd", rd, 32'h4);
    tick();
    check("prdata_idle", ifc.prdata, 32'h0);
    apb_write(4'h4, 32'h4);
    check("lvl_w1c_ign", 32'(irq_request), 32'h4);
    irq_in = 4'b0000;
    ticks(LAT - 1);
    check("lvl_fall_before", 32'(irq_request), 32'h4);
    tick();
    check("lvl_fall", 32'(irq_request), 32'h0);

    // Rising-edge capture on source 0
    apb_write(4'h0, 32'h01);
    irq_in[0] = 1'b1;
    for (int cyc = 1; cyc <= int'(LAT) + 1; cyc++) begin
      tick();
      if (cyc == int'(PW)) irq_in[0] = 1'b0;
      if (cyc == int'(LAT)) check("rise_before", 32'(irq_request), 32'h0);
      if (cyc == int'(LAT) + 1) check("rise_set", 32'(irq_request), 32'h1);
    end
    irq_in[0] = 1'b0;
    ticks(10);
    check("rise_sticky", 32'(irq_request), 32'h1);
    apb_write(4'h4, 32'h1);
    check("rise_w1c", 32'(irq_request), 32'h0);
    apb_read(4'h4, rd); check("rise_pend_rd", rd, 32'h0);

    // Both edges on source 3
    apb_write(4'h0, 32'hC0);
    irq_in[3] = 1'b1;
    ticks(LAT + 1);
    check("both_rise", 32'(irq_request), 32'h8);
    apb_write(4'h4, 32'h8);
    check("both_w1c1", 32'(irq_request), 32'h0);
    irq_in[3] = 1'b0;
    ticks(LAT);
    check("both_fall_before", 32'(irq_request), 32'h0);
    tick();
    check("both_fall", 32'(irq_request), 32'h8);
    apb_write(4'h4, 32'h8);
    check("both_w1c2", 32'(irq_request), 32'h0);
    // W1C commit lands on the same edge that sets pending
    irq_in[3] = 1'b1;
    ticks(LAT - 1);
    apb_write(4'h4, 32'h8);
    check("set_beats_w1c", 32'(irq_request), 32'h8);
    apb_write(4'h4, 32'h8);
    check("both_w1c3", 32'(irq_request), 32'h0);
    irq_in[3] = 1'b0;
    ticks(LAT + 1);
    apb_write(4'h4, 32'h8);
    check("both_w1c4", 32'(irq_request), 32'h0);

    // Mode change clears pending of changed fields only
    apb_write(4'h0, 32'h05);
    irq_in[1:0] = 2'b11;
    ticks(LAT + 1);
    check("mc_both_pend", 32'(irq_request), 32'h3);
    apb_write(4'h0, 32'h09);
    check("mc_clr_src1", 32'(irq_request), 32'h1);
    apb_write(4'h0, 32'h09);
    check("mc_same_mode", 32'(irq_request), 32'h1);
    apb_read(4'h0, rd); check("mc_mode_rd", rd, 32'h9);
    irq_in[1:0] = 2'b00;
    ticks(LAT + 1);
    check("mc_fall_src1", 32'(irq_request), 32'h3);
    apb_write(4'h4, 32'h3);
    check("mc_w1c", 32'(irq_request), 32'h0);

    // enable low freezes everything
    apb_write(4'h0, 32'h01);
    apb_read(4'h0, rd);
    enable = 1'b0;
    check("en_prdata_load", rd, 32'h1);
    irq_in[0] = 1'b1;
    ticks(3);
    irq_in[0] = 1'b0;
    apb_write(4'h0, 32'h3);
    ticks(3);
    check("en_prdata_hold", ifc.prdata, 32'h1);
    check("en_irq_hold", 32'(irq_request), 32'h0);
    enable = 1'b1;
    ticks(LAT + 2);
    check("en_edge_lost", 32'(irq_request), 32'h0);
    apb_read(4'h0, rd); check("en_mode_hold", rd, 32'h1);
    apb_read(4'h8, rd); check("en_raw", rd, 32'h0);
    irq_in[0] = 1'b1;
    ticks(PW);
    irq_in[0] = 1'b0;
    ticks(LAT + 2);
    check("en_pend_set", 32'(irq_request), 32'h1);
    enable = 1'b0;
    apb_write(4'h4, 32'h1);
    check("en_pend_hold", 32'(irq_request), 32'h1);
    enable = 1'b1;
    apb_write(4'h4, 32'h1);
    check("en_pend_w1c", 32'(irq_request), 32'h0);

`ifdef IRQ_CAPTURE_DEBOUNCE_EN
    // Short glitch rejected by the filter
    irq_in[0] = 1'b1;
    ticks(3);
    irq_in[0] = 1'b0;
    ticks(15);
    check("deb_glitch", 32'(irq_request), 32'h0);
    apb_read(4'h8, rd); check("deb_raw", rd, 32'h0);
`endif

    // Asynchronous reset mid-operation
    irq_in[0] = 1'b1;
    ticks(LAT + 1);
    check("pre_rst_pend", 32'(irq_request), 32'h1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_irq", 32'(irq_request), 32'h0);
    check("async_rst_prdata", ifc.prdata, 32'h0);
    irq_in[0] = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    apb_read(4'h0, rd); check("post_rst_mode", rd, 32'h0);
    check("post_rst_irq", 32'(irq_request), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
